sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for a single-port synchronous SRAM.
// m0 (CPU data) and m1 (UART loader) share the SRAM; round-robin in FREE,
// with an optional lock that keeps ownership for read-modify-write sequences.
// Optional per-master grant counters are built when SRAM_ARB_STATS_EN is defined.
module sram_port_arbiter #(
  parameter int unsigned ADR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  m0_req_i,
  input  logic                  m1_req_i,
  input  logic                  m0_we_i,
  input  logic                  m1_we_i,
  input  logic [ADR_WIDTH-1:0]  m0_adr_i,
  input  logic [ADR_WIDTH-1:0]  m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdat_i,
  input  logic [DATA_WIDTH-1:0] m1_wdat_i,
  input  logic                  m0_lock_i,
  input  logic                  m1_lock_i,
  output logic                  m0_gnt_o,
  output logic                  m1_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdat_o,
  output logic [DATA_WIDTH-1:0] m1_rdat_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [ADR_WIDTH-1:0]  sram_adr_o,
  output logic [DATA_WIDTH-1:0] sram_wdat_o,
  input  logic [DATA_WIDTH-1:0] sram_rdat_i,
  output logic [15:0]           m0_cnt_o,
  output logic [15:0]           m1_cnt_o
);

  typedef enum logic [1:0] {StFree, StLock0, StLock1} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  gnt0, gnt1;
  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdat0_q, rdat1_q;

  // State, round-robin pointer and read-return tracking
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StFree;
      rr_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdat0_q   <= '0;
      rdat1_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      rvalid0_q <= gnt0 & ~m0_we_i;
      rvalid1_q <= gnt1 & ~m1_we_i;
      // Hold the last returned word so rdat stays stable between reads
      if (rvalid0_q) rdat0_q <= sram_rdat_i;
      if (rvalid1_q) rdat1_q <= sram_rdat_i;
    end
  end

  // Grant decision and next-state; grants are forced low while in reset
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    rr_d    = rr_q;
    if (rst_n_i) begin
      unique case (state_q)
        StFree: begin
          if (m0_req_i && (!m1_req_i || !rr_q)) gnt0 = 1'b1;
          else if (m1_req_i)                    gnt1 = 1'b1;
          if (gnt0) begin
            rr_d = 1'b1;
            if (m0_lock_i) state_d = StLock0;
          end
          if (gnt1) begin
            rr_d = 1'b0;
            if (m1_lock_i) state_d = StLock1;
          end
        end
        StLock0: begin
          gnt0 = m0_req_i;
          if (!m0_lock_i) state_d = StFree;
        end
        StLock1: begin
          gnt1 = m1_req_i;
          if (!m1_lock_i) state_d = StFree;
        end
        default: state_d = StFree;
      endcase
    end
  end

  // SRAM port mux; everything zero when nobody is granted
  always_comb begin
    sram_we_o   = 1'b0;
    sram_adr_o  = '0;
    sram_wdat_o = '0;
    if (gnt0) begin
      sram_we_o   = m0_we_i;
      sram_adr_o  = m0_adr_i;
      sram_wdat_o = m0_wdat_i;
    end else if (gnt1) begin
      sram_we_o   = m1_we_i;
      sram_adr_o  = m1_adr_i;
      sram_wdat_o = m1_wdat_i;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign sram_en_o   = gnt0 | gnt1;
  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  // SRAM data arrives the cycle after the enable, so pass it straight through
  assign m0_rdat_o   = rvalid0_q ? sram_rdat_i : rdat0_q;
  assign m1_rdat_o   = rvalid1_q ? sram_rdat_i : rdat1_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Saturating grant counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1 && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign m0_cnt_o = cnt0_q;
  assign m1_cnt_o = cnt1_q;
`else
  assign m0_cnt_o = '0;
  assign m1_cnt_o = '0;
`endif

endmodule
